// File: rtl/key_entry_conditioner_if.sv
// rtl/key_entry_conditioner_if.sv - raw key/switch inputs and conditioned digit-entry outputs
interface key_entry_conditioner_if;
   logic       key_enter_n;
   logic       key_clear_n;
   logic [3:0] sw;
   logic       enter;
   logic       clear;
   logic [3:0] digit;
   logic [2:0] entries;
   logic       full;

   modport master (
      output key_enter_n, key_clear_n, sw,
      input  enter, clear, digit, entries, full
   );

   modport slave (
      input  key_enter_n, key_clear_n, sw,
      output enter, clear, digit, entries, full
   );
endinterface

// File: rtl/key_entry_conditioner.sv
// rtl/key_entry_conditioner.sv - pushbutton sync/debounce to pulses, digit capture, entry count
module key_entry_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic level_i,     // synchronised button level, low = pressed
   output logic confirm_o    // high in the cycle whose edge accepts a press
);
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      PRESSED   = 2'd2,
      REL_CHK   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;

   // Press and release both need a full stable window; a held key never re-fires.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!level_i) begin
                  state_q <= PRESS_CHK;
                  cnt_q   <= '0;
               end
            end
            PRESS_CHK: begin
               if (level_i) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= PRESSED;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (level_i) begin
                  state_q <= REL_CHK;
                  cnt_q   <= '0;
               end
            end
            REL_CHK: begin
               if (!level_i) begin
                  state_q <= PRESSED;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Confirmation is the PRESS_CHK->PRESSED transition; the top registers it as the pulse.
   assign confirm_o = (state_q == PRESS_CHK) && !level_i && (cnt_q == CNT_LAST);
endmodule

module key_entry_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int CODE_LEN        = 6
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   key_entry_conditioner_if.slave         kif
);
   localparam logic [2:0] ENTRIES_MAX = 3'(CODE_LEN);

   logic       enter_meta_q, enter_sync_q;
   logic       clear_meta_q, clear_sync_q;
   logic [3:0] sw_meta_q, sw_sync_q;

   logic       enter_confirm, clear_confirm;

   logic       enter_q, enter_d;
   logic       clear_q, clear_d;
   logic [3:0] digit_q, digit_d;
   logic [2:0] entries_q, entries_d;

   // Two-flop synchronisers; keys rest released (high) out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enter_meta_q <= 1'b1;
         enter_sync_q <= 1'b1;
         clear_meta_q <= 1'b1;
         clear_sync_q <= 1'b1;
         sw_meta_q    <= 4'h0;
         sw_sync_q    <= 4'h0;
      end else begin
         enter_meta_q <= kif.key_enter_n;
         enter_sync_q <= enter_meta_q;
         clear_meta_q <= kif.key_clear_n;
         clear_sync_q <= clear_meta_q;
         sw_meta_q    <= kif.sw;
         sw_sync_q    <= sw_meta_q;
      end
   end

   key_entry_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_enter_db (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .level_i   (enter_sync_q),
      .confirm_o (enter_confirm)
   );

   key_entry_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_clear_db (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .level_i   (clear_sync_q),
      .confirm_o (clear_confirm)
   );

   // Clear dominates a simultaneous enter; digit and count update on the pulse edge itself.
   always_comb begin
      enter_d   = 1'b0;
      clear_d   = 1'b0;
      digit_d   = digit_q;
      entries_d = entries_q;
      if (clear_confirm) begin
         clear_d   = 1'b1;
         digit_d   = 4'h0;
         entries_d = 3'd0;
      end else if (enter_confirm) begin
         enter_d = 1'b1;
         digit_d = sw_sync_q;
         if (entries_q < ENTRIES_MAX) begin
            entries_d = entries_q + 3'd1;
         end
      end
   end

   // Registered pulses and entry state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enter_q   <= 1'b0;
         clear_q   <= 1'b0;
         digit_q   <= 4'h0;
         entries_q <= 3'd0;
      end else begin
         enter_q   <= enter_d;
         clear_q   <= clear_d;
         digit_q   <= digit_d;
         entries_q <= entries_d;
      end
   end

   assign kif.enter   = enter_q;
   assign kif.clear   = clear_q;
   assign kif.digit   = digit_q;
   assign kif.entries = entries_q;
   assign kif.full    = (entries_q == ENTRIES_MAX);
endmodule

// File: tb/tb_key_entry_conditioner.sv
// tb/tb_key_entry_conditioner.sv - scoreboard bench for key_entry_conditioner
module tb_key_entry_conditioner;
   localparam int D       = 4;
   localparam int LAT     = D + 3;
   localparam int CODE    = 6;

   typedef struct {
      int         cyc;
      logic [9:0] outs;   // {enter, clear, digit, entries, full}
   } ev_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_err;
   ev_t  sb[$];

   int         m_entries;
   logic [3:0] m_digit;

   key_entry_conditioner_if kif ();

   key_entry_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3),
      .CODE_LEN        (CODE)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .kif    (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [9:0] outs_now();
      return {kif.enter, kif.clear, kif.digit, kif.entries, kif.full};
   endfunction

   always @(negedge clk) begin : monitor
      ev_t e;
      if (rst_n && (kif.enter || kif.clear)) begin
         if (sb.size() == 0) begin
            chk("unexp_pulse", {30'd0, kif.enter, kif.clear}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ev_cyc", cyc, e.cyc);
            chk("ev_outs", {22'd0, outs_now()}, {22'd0, e.outs});
         end
      end
   end

   task automatic push_enter(input int t0, input logic [3:0] s);
      ev_t e;
      m_digit = s;
      if (m_entries < CODE) m_entries++;
      e.cyc  = t0 + LAT;
      e.outs = {1'b1, 1'b0, s, 3'(m_entries), (m_entries == CODE)};
      sb.push_back(e);
   endtask

   task automatic push_clear(input int t0);
      ev_t e;
      m_digit   = 4'h0;
      m_entries = 0;
      e.cyc  = t0 + LAT;
      e.outs = {1'b0, 1'b1, 4'h0, 3'd0, 1'b0};
      sb.push_back(e);
   endtask

   task automatic press(input bit do_enter, input bit do_clear, input logic [3:0] s, input int hold);
      int t0;
      @(negedge clk);
      kif.sw = s;
      if (do_enter) kif.key_enter_n = 1'b0;
      if (do_clear) kif.key_clear_n = 1'b0;
      t0 = cyc;
      if (do_clear) push_clear(t0);
      else if (do_enter) push_enter(t0, s);
      repeat (hold) @(negedge clk);
      kif.key_enter_n = 1'b1;
      kif.key_clear_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int t1;
      cyc   = 0;
      n_vec = 0;
      n_err = 0;
      m_entries = 0;
      m_digit   = 4'h0;
      rst_n = 1'b0;
      kif.key_enter_n = 1'b1;
      kif.key_clear_n = 1'b1;
      kif.sw = 4'h0;

      // 1: reset and idle
      repeat (3) @(negedge clk);
      chk("rst_outs", {22'd0, outs_now()}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outs", {22'd0, outs_now()}, 32'd0);
      end

      // 2: single long press
      press(1'b1, 1'b0, 4'h4, 12);
      chk("t2_entries", {29'd0, kif.entries}, 32'd1);
      chk("t2_digit", {28'd0, kif.digit}, 32'd4);

      // 3: bouncing key rejected
      for (int i = 0; i < 4; i++) begin
         kif.key_enter_n = 1'b0;
         repeat (2) @(negedge clk);
         kif.key_enter_n = 1'b1;
         repeat (2) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      chk("t3_entries", {29'd0, kif.entries}, 32'd1);

      // 4: seven presses from empty, saturating at CODE_LEN
      press(1'b0, 1'b1, 4'h0, 8);
      begin
         logic [3:0] seq [7];
         seq = '{4'h8, 4'h3, 4'h8, 4'h1, 4'h5, 4'h9, 4'h2};
         for (int i = 0; i < 7; i++) press(1'b1, 1'b0, seq[i], 8);
      end
      chk("t4_digit", {28'd0, kif.digit}, 32'd2);
      chk("t4_entries", {29'd0, kif.entries}, 32'd6);
      chk("t4_full", {31'd0, kif.full}, 32'd1);

      // 5: simultaneous enter and clear with entries=3
      press(1'b0, 1'b1, 4'h0, 8);
      press(1'b1, 1'b0, 4'hA, 8);
      press(1'b1, 1'b0, 4'hB, 8);
      press(1'b1, 1'b0, 4'hC, 8);
      chk("t5_pre_entries", {29'd0, kif.entries}, 32'd3);
      press(1'b1, 1'b1, 4'h6, 10);
      chk("t5_outs", {22'd0, outs_now()}, 32'd0);

      // 6: reset during PRESS_CHK, key held through release
      press(1'b1, 1'b0, 4'h3, 8);
      @(negedge clk);
      kif.sw = 4'h7;
      kif.key_enter_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      m_entries = 0;
      m_digit   = 4'h0;
      repeat (3) begin
         @(negedge clk);
         chk("t6_rst_outs", {22'd0, outs_now()}, 32'd0);
      end
      rst_n = 1'b1;
      t1 = cyc;
      push_enter(t1, 4'h7);
      repeat (12) @(negedge clk);
      kif.key_enter_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("t6_entries", {29'd0, kif.entries}, 32'd1);
      chk("t6_digit", {28'd0, kif.digit}, 32'd7);

      repeat (20) @(negedge clk);
      chk("sb_drain", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
